fx2_in_mux: RTL and testbench
=============================

# fx2_in_mux

Parametrised successor to the single-stream FX2 write path. Arbitrates N_CHAN independent byte streams (tagger samples, command replies, status) onto one FX2 slave-FIFO IN endpoint. It uses round-robin packet-granular grants and handles USB packet boundaries itself: explicit end-of-message, full-packet auto-commit, and idle-timeout flush of short packets. It sits between the tagger/reply sources and the FX2 pins, on the FX2 clock domain.

## Interface
Parameters:
- N_CHAN, 2, number of source streams (1..8)
- MAX_PKT, 512, endpoint packet size in bytes (power of two)
- IDLE_TIMEOUT, 1024, source-idle cycles before a partial packet is flushed (≥1)
- EP_ADDR, 2'b10, constant driven on fx2_fifoadr (EP6)

Ports:
- fx2_clk  in  1  sole clock
- reset_n  in  1  reset, synchronous, active-low
- src_data  in  8*N_CHAN  channel c byte at [8c+7:8c]
- src_rdy  in  N_CHAN  channel c has a valid byte
- src_end  in  N_CHAN  qualifies src_data: last byte of a message
- src_ack  out  N_CHAN  combinational accept; byte consumed on this edge
- fx2_full_n  in  1  FX2 IN FIFO not full (flag, active-high)
- fx2_fd_out  out  8  write data to pad driver
- fx2_slwr  out  1  write strobe, active-low
- fx2_pktend  out  1  packet commit, active-low
- fx2_fifoadr  out  2  = EP_ADDR
- grant  out  $clog2(N_CHAN) (min 1)  current owner
- grant_valid  out  1  a channel owns the endpoint
- byte_count  out  $clog2(MAX_PKT)+1  bytes written in current packet

## Operation
- FSM states: IDLE, XFER, PKTEND.
- IDLE: if any src_rdy, register grant = first channel with src_rdy, scanning from rr_ptr upward mod N_CHAN; grant_valid←1; →XFER. Otherwise stay.
- XFER: src_ack[grant] = src_rdy[grant] & fx2_full_n (others 0). On accept: fd←data, slwr←0 next cycle, byte_count+1, idle counter←0.
  - Accepted byte with byte_count reaching MAX_PKT: FX2 auto-commits, so no pktend is issued. byte_count←0, release grant →IDLE. This applies even when src_end is also set.
  - Accepted byte with src_end and count<MAX_PKT: →PKTEND.
  - src_rdy[grant] low: idle counter+1. At IDLE_TIMEOUT: if byte_count>0 →PKTEND, else release →IDLE.
  - fx2_full_n low with src_rdy high is a stall. The idle counter holds during a stall.
- PKTEND: wait for fx2_full_n high, then pulse fx2_pktend low for 1 cycle. byte_count←0, release →IDLE.
- Release: rr_ptr←grant+1 mod N_CHAN, grant_valid←0.
- Reset values: fx2_slwr=1, fx2_pktend=1, fx2_fd_out=0, src_ack=0, grant=0, grant_valid=0, byte_count=0, rr_ptr=0, idle counter=0, state IDLE.
- Reset mid-packet: the next edge forces every output to its reset value. No pktend is issued; bytes already in the FX2 stay there.

## Timing
- Accept in cycle t → fx2_slwr low and fx2_fd_out valid in t+1, exactly one cycle per byte. Sustained throughput is 1 byte/cycle.
- Grant latency: src_rdy seen in IDLE at t → first accept possible at t+1.
- Release → new grant: minimum 1 IDLE cycle.
- fx2_pktend is never low in the same cycle as fx2_slwr. At least 1 cycle separates the last slwr from pktend.
- fx2_fifoadr is constant.

## Structure
- Package fx2_pkg: state enum; EP2/EP4/EP6/EP8 address constants; default MAX_PKT.
- Sub-module fx2_rr_pick: combinational round-robin picker. Inputs are the request vector and rr_ptr; outputs are the index and a valid flag.

## Test plan
- N_CHAN=2; ch0 sends 3 bytes 0xA1,0xA2,0xA3 with src_end on 0xA3 → 3 consecutive slwr pulses carrying those bytes, then 1 gap cycle, then one pktend pulse; byte_count returns to 0.
- ch0 streams 512 bytes, no end → 512 slwr, no pktend, grant released at byte 512.
- ch0 sends 5 bytes then idles → pktend pulse exactly IDLE_TIMEOUT cycles after the last accept, plus 1.
- ch0 and ch1 both continuously ready, with 4-byte messages ending in src_end → grants alternate 0,1,0,1; no interleaving of bytes within a packet.
- fx2_full_n low for 20 cycles mid-stream → src_ack 0, no slwr, no timeout fires; resumes at the next byte with no loss or duplication.
- reset_n low for 1 cycle with byte_count=7 → next cycle every output at its reset value, no pktend; the next grant goes to ch0.

Source files
------------

// File: rtl/fx2_in_mux_pkg.sv
// Shared state encoding, endpoint addresses and sizing helpers for the FX2 IN mux.
package fx2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_PKTEND
  } state_t;

  localparam logic [1:0] EP2_ADDR = 2'b00;
  localparam logic [1:0] EP4_ADDR = 2'b01;
  localparam logic [1:0] EP6_ADDR = 2'b10;
  localparam logic [1:0] EP8_ADDR = 2'b11;

  localparam int DEFAULT_MAX_PKT = 512;

  // Grant index width; a single channel still gets a 1-bit index.
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fx2_in_mux_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping mod N_CHAN.
module fx2_rr_pick
  import fx2_pkg::*;
#(
  parameter int N_CHAN = 2
) (
  input  logic [N_CHAN-1:0]          req_i,
  input  logic [grant_w(N_CHAN)-1:0] ptr_i,
  output logic [grant_w(N_CHAN)-1:0] idx_o,
  output logic                       vld_o
);

  localparam int GW = grant_w(N_CHAN);

  logic [GW-1:0] cand;

  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    cand  = ptr_i;
    for (int i = 0; i < N_CHAN; i++) begin
      if (!vld_o && req_i[cand]) begin
        vld_o = 1'b1;
        idx_o = cand;
      end
      cand = (cand == GW'(N_CHAN - 1)) ? '0 : cand + GW'(1);
    end
  end

endmodule

// File: rtl/fx2_in_mux.sv
// Round-robin, packet-granular mux of N byte streams onto one FX2 slave-FIFO IN endpoint.
// Accept at t drives slwr/fd at t+1; stalls while fx2_full_n is low, commits short packets with pktend.
module fx2_in_mux
  import fx2_pkg::*;
#(
  parameter int         N_CHAN       = 2,
  parameter int         MAX_PKT      = DEFAULT_MAX_PKT,
  parameter int         IDLE_TIMEOUT = 1024,
  parameter logic [1:0] EP_ADDR      = EP6_ADDR
) (
  input  logic                          fx2_clk,
  input  logic                          reset_n,
  input  logic [8*N_CHAN-1:0]           src_data,
  input  logic [N_CHAN-1:0]             src_rdy,
  input  logic [N_CHAN-1:0]             src_end,
  output logic [N_CHAN-1:0]             src_ack,
  input  logic                          fx2_full_n,
  output logic [7:0]                    fx2_fd_out,
  output logic                          fx2_slwr,
  output logic                          fx2_pktend,
  output logic [1:0]                    fx2_fifoadr,
  output logic [grant_w(N_CHAN)-1:0]    grant,
  output logic                          grant_valid,
  output logic [$clog2(MAX_PKT):0]      byte_count
);

  localparam int GW = grant_w(N_CHAN);
  localparam int CW = $clog2(MAX_PKT) + 1;
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic          grant_vld_q, grant_vld_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [7:0]    fd_q, fd_d;
  logic          slwr_q, slwr_d;
  logic          pktend_q, pktend_d;

  logic [GW-1:0] pick_idx;
  logic          pick_vld;
  logic [7:0]    src_byte [N_CHAN];
  logic          sel_rdy, sel_end, accept;
  logic [GW-1:0] rel_ptr;

  for (genvar c = 0; c < N_CHAN; c++) begin : g_byte
    assign src_byte[c] = src_data[8*c +: 8];
  end

  fx2_rr_pick #(.N_CHAN(N_CHAN)) u_pick (
    .req_i (src_rdy),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  // Gated by reset_n so a source never loses a byte to the reset edge.
  assign sel_rdy = src_rdy[grant_q];
  assign sel_end = src_end[grant_q];
  assign accept  = reset_n && (state_q == ST_XFER) && sel_rdy && fx2_full_n;
  assign rel_ptr = (grant_q == GW'(N_CHAN - 1)) ? '0 : grant_q + GW'(1);

  always_comb begin
    src_ack          = '0;
    src_ack[grant_q] = accept;
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    grant_vld_d = grant_vld_q;
    cnt_d       = cnt_q;
    idle_d      = idle_q;
    fd_d        = fd_q;
    slwr_d      = 1'b1;
    pktend_d    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d     = pick_idx;
          grant_vld_d = 1'b1;
          idle_d      = '0;
          state_d     = ST_XFER;
        end
      end
      ST_XFER: begin
        if (accept) begin
          fd_d   = src_byte[grant_q];
          slwr_d = 1'b0;
          idle_d = '0;
          // A full packet is committed by the FX2 itself, even if src_end is also set.
          if (cnt_q == CW'(MAX_PKT - 1)) begin
            cnt_d       = '0;
            grant_vld_d = 1'b0;
            rr_ptr_d    = rel_ptr;
            state_d     = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
            if (sel_end) state_d = ST_PKTEND;
          end
        end else if (!sel_rdy) begin
          if (idle_q == IW'(IDLE_TIMEOUT - 1)) begin
            idle_d = '0;
            if (cnt_q != '0) begin
              state_d = ST_PKTEND;
            end else begin
              grant_vld_d = 1'b0;
              rr_ptr_d    = rel_ptr;
              state_d     = ST_IDLE;
            end
          end else begin
            idle_d = idle_q + IW'(1);
          end
        end
      end
      ST_PKTEND: begin
        // Waiting for slwr_q high keeps a gap cycle between the last strobe and pktend.
        if (fx2_full_n && slwr_q) begin
          pktend_d    = 1'b0;
          cnt_d       = '0;
          grant_vld_d = 1'b0;
          rr_ptr_d    = rel_ptr;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge fx2_clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      grant_vld_q <= 1'b0;
      cnt_q       <= '0;
      idle_q      <= '0;
      fd_q        <= '0;
      slwr_q      <= 1'b1;
      pktend_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_vld_q <= grant_vld_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      fd_q        <= fd_d;
      slwr_q      <= slwr_d;
      pktend_q    <= pktend_d;
    end
  end

  assign fx2_fd_out  = fd_q;
  assign fx2_slwr    = slwr_q;
  assign fx2_pktend  = pktend_q;
  assign fx2_fifoadr = EP_ADDR;
  assign grant       = grant_q;
  assign grant_valid = grant_vld_q;
  assign byte_count  = cnt_q;

endmodule

// File: tb/tb_fx2_in_mux.sv
// Directed bench for fx2_in_mux: cycle table for a short message plus hand-written multi-cycle sequences.
module tb_fx2_in_mux;

  localparam int IT = 16;

  logic        fx2_clk = 1'b0;
  logic        reset_n;
  logic [15:0] src_data;
  logic [1:0]  src_rdy, src_end, src_ack;
  logic        fx2_full_n;
  logic [7:0]  fx2_fd_out;
  logic        fx2_slwr, fx2_pktend;
  logic [1:0]  fx2_fifoadr;
  logic [0:0]  grant;
  logic        grant_valid;
  logic [9:0]  byte_count;

  fx2_in_mux #(.N_CHAN(2), .MAX_PKT(512), .IDLE_TIMEOUT(IT), .EP_ADDR(2'b10)) dut (
    .fx2_clk(fx2_clk), .reset_n(reset_n), .src_data(src_data), .src_rdy(src_rdy),
    .src_end(src_end), .src_ack(src_ack), .fx2_full_n(fx2_full_n), .fx2_fd_out(fx2_fd_out),
    .fx2_slwr(fx2_slwr), .fx2_pktend(fx2_pktend), .fx2_fifoadr(fx2_fifoadr),
    .grant(grant), .grant_valid(grant_valid), .byte_count(byte_count)
  );

  always #5 fx2_clk = ~fx2_clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus monitor
  int         cyc = 0;
  logic [7:0] wq[$];
  int         pk_cnt = 0, pk_cyc = 0, last_wr_cyc = 0;
  int         overlap = 0, adr_bad = 0;
  logic       gv_prev = 1'b0;
  logic [0:0] gseq[$];

  always @(posedge fx2_clk) cyc++;

  always @(negedge fx2_clk) begin
    if (reset_n) begin
      if (!fx2_slwr) begin
        wq.push_back(fx2_fd_out);
        last_wr_cyc = cyc;
      end
      if (!fx2_pktend) begin
        pk_cnt++;
        pk_cyc = cyc;
      end
      if (!fx2_slwr && !fx2_pktend) overlap++;
      if (fx2_fifoadr !== 2'b10) adr_bad++;
      if (grant_valid && !gv_prev) gseq.push_back(grant);
    end
    gv_prev = grant_valid;
  end

  task automatic do_reset();
    reset_n    = 1'b0;
    src_rdy    = '0;
    src_end    = '0;
    src_data   = '0;
    fx2_full_n = 1'b1;
    @(posedge fx2_clk);
    @(posedge fx2_clk);
    #1;
    reset_n = 1'b1;
  endtask

  int stall_ack_err = 0, stall_wr_err = 0;

  // Single-channel source: n bytes base+k, optional src_end on the last, optional full_n stall.
  task automatic drive_one(input int ch, input int n, input logic [7:0] base, input bit end_last,
                           input int stall_at, input int stall_len, input int budget);
    int  sent = 0;
    int  stall_left = 0;
    bit  stalled = 0;
    for (int k = 0; k < budget && sent < n; k++) begin
      src_rdy             = '0;
      src_end             = '0;
      src_rdy[ch]         = 1'b1;
      src_data[8*ch +: 8] = base + 8'(sent);
      src_end[ch]         = end_last && (sent == n - 1);
      fx2_full_n          = (stall_left == 0);
      @(negedge fx2_clk);
      if (stall_left > 0) begin
        if (src_ack != 2'b00) stall_ack_err++;
        if (!fx2_slwr && stall_left < stall_len) stall_wr_err++;
        stall_left--;
      end else if (src_ack[ch]) begin
        sent++;
        if (!stalled && stall_len > 0 && sent == stall_at) begin
          stall_left = stall_len;
          stalled    = 1;
        end
      end
      @(posedge fx2_clk);
      #1;
    end
    src_rdy    = '0;
    src_end    = '0;
    fx2_full_n = 1'b1;
    check("stream_done", sent, n);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) @(posedge fx2_clk);
    #1;
  endtask

  typedef struct {
    logic       rdy;
    logic       endb;
    logic [7:0] dat;
    logic [1:0] ack;
    logic       slwr;
    logic       pktend;
    logic       gv;
    logic [9:0] bc;
    logic       chk_fd;
    logic [7:0] fd;
  } vec_t;

  vec_t tv[8];
  int   pk0, bad;
  logic [7:0] exp_b;

  initial begin
    // ch0 message A1 A2 A3 (end on A3): strobes in cycles 2-4, gap in 5, pktend in 6
    tv[0] = '{1'b1, 1'b0, 8'hA1, 2'b00, 1'b1, 1'b1, 1'b0, 10'd0, 1'b0, 8'h00};
    tv[1] = '{1'b1, 1'b0, 8'hA1, 2'b01, 1'b1, 1'b1, 1'b1, 10'd0, 1'b0, 8'h00};
    tv[2] = '{1'b1, 1'b0, 8'hA2, 2'b01, 1'b0, 1'b1, 1'b1, 10'd1, 1'b1, 8'hA1};
    tv[3] = '{1'b1, 1'b1, 8'hA3, 2'b01, 1'b0, 1'b1, 1'b1, 10'd2, 1'b1, 8'hA2};
    tv[4] = '{1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b1, 10'd3, 1'b1, 8'hA3};
    tv[5] = '{1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b1, 1'b1, 10'd3, 1'b0, 8'h00};
    tv[6] = '{1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 8'h00};
    tv[7] = '{1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b1, 1'b0, 10'd0, 1'b0, 8'h00};

    do_reset();
    @(negedge fx2_clk);
    check("rst_slwr", fx2_slwr, 1);
    check("rst_pktend", fx2_pktend, 1);
    check("rst_fd", fx2_fd_out, 0);
    check("rst_ack", src_ack, 0);
    check("rst_gv", grant_valid, 0);
    check("rst_bc", byte_count, 0);
    check("fifoadr", fx2_fifoadr, 2'b10);
    @(posedge fx2_clk);
    #1;

    // Short message, cycle by cycle
    for (int i = 0; i < 8; i++) begin
      src_rdy       = {1'b0, tv[i].rdy};
      src_end       = {1'b0, tv[i].endb};
      src_data[7:0] = tv[i].dat;
      @(negedge fx2_clk);
      check($sformatf("t1_ack[%0d]", i), src_ack, tv[i].ack);
      check($sformatf("t1_slwr[%0d]", i), fx2_slwr, tv[i].slwr);
      check($sformatf("t1_pktend[%0d]", i), fx2_pktend, tv[i].pktend);
      check($sformatf("t1_gv[%0d]", i), grant_valid, tv[i].gv);
      check($sformatf("t1_bc[%0d]", i), byte_count, tv[i].bc);
      if (tv[i].chk_fd) check($sformatf("t1_fd[%0d]", i), fx2_fd_out, tv[i].fd);
      if (tv[i].gv) check($sformatf("t1_grant[%0d]", i), grant, 0);
      @(posedge fx2_clk);
      #1;
    end

    // Full 512-byte packet without src_end: auto-commit, no pktend, grant released
    wq.delete();
    pk0 = pk_cnt;
    drive_one(0, 512, 8'h00, 1'b0, 0, 0, 2000);
    @(negedge fx2_clk);
    check("t2_gv_released", grant_valid, 0);
    check("t2_bc_zero", byte_count, 0);
    idle_cycles(3 * IT);
    check("t2_nbytes", wq.size(), 512);
    bad = 0;
    for (int i = 0; i < wq.size(); i++) begin
      exp_b = 8'(i);
      if (wq[i] !== exp_b) bad++;
    end
    check("t2_data_errs", bad, 0);
    check("t2_no_pktend", pk_cnt - pk0, 0);

    // Five bytes then idle: timeout flush
    wq.delete();
    pk0 = pk_cnt;
    drive_one(0, 5, 8'h50, 1'b0, 0, 0, 100);
    for (int k = 0; k < 4 * IT && pk_cnt == pk0; k++) @(posedge fx2_clk);
    #1;
    check("t3_pktend_cnt", pk_cnt - pk0, 1);
    check("t3_pktend_delay", pk_cyc - last_wr_cyc, IT + 1);
    check("t3_nbytes", wq.size(), 5);
    @(negedge fx2_clk);
    check("t3_bc_zero", byte_count, 0);
    @(posedge fx2_clk);
    #1;

    // Both channels continuously ready with 4-byte messages
    do_reset();
    wq.delete();
    gseq.delete();
    pk0 = pk_cnt;
    begin
      int sent[2];
      sent[0] = 0;
      sent[1] = 0;
      for (int k = 0; k < 300 && (sent[0] < 8 || sent[1] < 8); k++) begin
        for (int c = 0; c < 2; c++) begin
          src_rdy[c]         = (sent[c] < 8);
          src_data[8*c +: 8] = (c == 1 ? 8'h80 : 8'h00) + 8'(sent[c]);
          src_end[c]         = (sent[c] % 4 == 3);
        end
        @(negedge fx2_clk);
        for (int c = 0; c < 2; c++) if (src_ack[c]) sent[c]++;
        @(posedge fx2_clk);
        #1;
      end
      src_rdy = '0;
      src_end = '0;
      check("t4_sent0", sent[0], 8);
      check("t4_sent1", sent[1], 8);
    end
    idle_cycles(8);
    check("t4_ngrants", gseq.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < gseq.size()) check($sformatf("t4_grant[%0d]", i), gseq[i], i % 2);
    check("t4_nbytes", wq.size(), 16);
    bad = 0;
    for (int i = 0; i < wq.size(); i++) begin
      exp_b = ((i / 4) % 2 == 1 ? 8'h80 : 8'h00) + 8'((i / 8) * 4 + i % 4);
      if (wq[i] !== exp_b) bad++;
    end
    check("t4_order_errs", bad, 0);
    check("t4_pktends", pk_cnt - pk0, 4);

    // Stall of 20 cycles mid-stream (longer than the idle timeout)
    wq.delete();
    pk0 = pk_cnt;
    stall_ack_err = 0;
    stall_wr_err  = 0;
    drive_one(0, 8, 8'h30, 1'b1, 3, 20, 200);
    idle_cycles(6);
    check("t5_stall_ack", stall_ack_err, 0);
    check("t5_stall_wr", stall_wr_err, 0);
    check("t5_nbytes", wq.size(), 8);
    bad = 0;
    for (int i = 0; i < wq.size(); i++) begin
      exp_b = 8'h30 + 8'(i);
      if (wq[i] !== exp_b) bad++;
    end
    check("t5_data_errs", bad, 0);
    check("t5_pktends", pk_cnt - pk0, 1);

    // Reset mid-packet on ch1 with 7 bytes written; rr_ptr currently points at ch1
    drive_one(1, 7, 8'h70, 1'b0, 0, 0, 100);
    pk0     = pk_cnt;
    reset_n = 1'b0;
    @(negedge fx2_clk);
    check("t6_pre_bc", byte_count, 7);
    check("t6_pre_grant", grant, 1);
    @(posedge fx2_clk);
    #1;
    reset_n = 1'b1;
    src_rdy = 2'b11;
    @(negedge fx2_clk);
    check("t6_slwr", fx2_slwr, 1);
    check("t6_pktend", fx2_pktend, 1);
    check("t6_fd", fx2_fd_out, 0);
    check("t6_ack", src_ack, 0);
    check("t6_grant", grant, 0);
    check("t6_gv", grant_valid, 0);
    check("t6_bc", byte_count, 0);
    @(posedge fx2_clk);
    #1;
    src_rdy = 2'b00;
    @(negedge fx2_clk);
    check("t6_next_gv", grant_valid, 1);
    check("t6_next_grant", grant, 0);
    check("t6_no_pktend", pk_cnt - pk0, 0);
    @(posedge fx2_clk);
    #1;

    check("slwr_pktend_overlap", overlap, 0);
    check("fifoadr_changes", adr_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
